cpu_trace_buffer: RTL and testbench
===================================

Name: cpu_trace_buffer

Overview:
- Parametrised, triggerable CPU-bus trace recorder. It generalises the single-sample trace latch that feeds the ICD controller into a circular history buffer.
- Samples a TRACE_W-bit bus snapshot on every trace_catch_i pulse (the phaser's release_cs strobe) into block RAM of depth 2**DEPTH_LOG2.
- Stops a programmable number of samples after a masked-compare or external trigger.
- The ICD controller reads the capture out oldest-first.

Parameters:
- TRACE_W, 40: width of one trace sample.
- DEPTH_LOG2, 9: log2 of buffer depth (512 entries).

Ports:
- clk6x  in  1  system clock (48 MHz).
- resetn  in  1  asynchronous active-low reset.
- trace_i  in  TRACE_W  bus snapshot.
- trace_catch_i  in  1  one-cycle sample strobe.
- arm_i  in  1  pulse: clear buffer and start capture.
- disarm_i  in  1  pulse: manual stop.
- trig_mask_i  in  TRACE_W  compare mask (1 = bit compared).
- trig_value_i  in  TRACE_W  compare value.
- trig_ext_i  in  1  external trigger, level, sampled only on catch cycles.
- post_count_i  in  DEPTH_LOG2  samples stored after the trigger sample; sampled at arm.
- rd_pop_i  in  1  consume the current rd_data_o.
- rd_data_o  out  TRACE_W  oldest unread sample.
- rd_valid_o  out  1  rd_data_o holds a valid sample.
- state_o  out  2  0 = IDLE, 1 = ARMED, 2 = POST, 3 = DONE.
- triggered_o  out  1  trigger occurred in this capture.
- wrapped_o  out  1  buffer overwrote older samples.
- count_o  out  DEPTH_LOG2+1  stored/unread sample count.

Behaviour:
- Reset (async, any state): state IDLE; all pointers and counters 0; rd_data_o 0; rd_valid_o, triggered_o, wrapped_o 0.
- Trigger hit = trace_catch_i & (((trace_i ^ trig_value_i) & trig_mask_i) == 0 | trig_ext_i). A mask of all zeros therefore triggers on the first catch.
- IDLE: catches ignored. arm_i -> ARMED.
- arm_i in any state:
  - Next cycle: state ARMED; wr_ptr, rd_ptr, count_o 0; triggered_o and wrapped_o 0.
  - post_count_i is latched.
  - A catch in the arm cycle itself is not stored.
  - arm_i wins over a simultaneous disarm_i.
- ARMED: each catch writes trace_i at wr_ptr, and wr_ptr increments modulo depth.
  - count_o saturates at 2**DEPTH_LOG2.
  - wrapped_o sets on the first write when count_o is already full.
  - A catch with trigger hit stores the sample and sets triggered_o.
  - It then goes to POST with post_left = latched post_count, or to DONE if post_count == 0.
- POST: each catch stores a sample (no trigger check) and decrements post_left. The store that makes post_left 0 transitions to DONE.
  - post_count is clamped to depth-1, so the trigger sample is never overwritten.
- disarm_i in ARMED or POST: DONE next cycle. A catch in the same cycle is stored; triggered_o is unchanged. disarm_i in IDLE or DONE is ignored.
- Entering DONE:
  - rd_ptr = wr_ptr if wrapped_o, else 0.
  - The first sample appears on rd_data_o with rd_valid_o = 1 exactly 2 cycles after the state change (synchronous RAM read + output register).
  - rd_valid_o stays 0 if count_o == 0.
- Read handshake (DONE only):
  - rd_pop_i with rd_valid_o = 1: rd_valid_o drops next cycle, count_o decrements, rd_ptr increments modulo depth.
  - The next sample is valid 2 cycles after the pop.
  - A pop with rd_valid_o = 0, or outside DONE, is ignored.
  - When count_o reaches 0, rd_valid_o stays 0 and the state remains DONE until arm.
- Catches in DONE are ignored; the buffer is frozen.
- RAM: single write port, single synchronous read port, no read-during-write case (writes occur only in ARMED/POST, reads only in DONE).

Decomposition:
- Shared package nora_pkg holds:
  - state encodings TR_IDLE / TR_ARMED / TR_POST / TR_DONE;
  - default TRACE_W = 40 and the trace-bit field offsets (address [39:24], data [23:16], control [11:0]).
- One sub-module: trace_ram, a simple dual-port synchronous RAM, parameters W and AW, ports clk6x / we / waddr / wdata / raddr / rdata. It infers iCE40 EBR.

Test Plan:
- Fill and no trigger:
  - Stimulus: mask 0xFF_FFFF_FFFF, value unmatched, 600 catches with trace = index, then disarm.
  - Response: count_o 512, wrapped_o 1, triggered_o 0. Readout yields 88..599 in order, then rd_valid_o 0.
- Masked trigger:
  - Stimulus: mask = 0xFFFF000000 (address field), value = 0xFFFC000000, post_count 3; send 10 catches with address 0x1000+i, then address 0xFFFC, then 5 more.
  - Response: DONE after the 3rd post catch, count_o 14. Readout ends with the 0xFFFC sample followed by 3 samples.
- post_count 0 with external trigger: trig_ext_i high on the 5th catch -> DONE the next cycle, count_o 5, the 6th catch is not stored.
- Read latency:
  - Stimulus: enter DONE with 2 samples.
  - Response: rd_valid_o goes high exactly 2 cycles after state_o = 3. Pop -> low 1 cycle, next sample valid 2 cycles after the pop. A pop while invalid does not change count_o.
- Simultaneous and illegal events:
  - arm_i + disarm_i + catch in one cycle -> ARMED, count_o 0.
  - disarm_i in IDLE -> stays IDLE.
  - rd_pop_i in ARMED -> ignored.
- Async reset mid-POST: assert resetn low between clock edges -> outputs 0 and state IDLE immediately. After release, arm restarts cleanly with count_o 0.

Source files
------------

// File: rtl/nora_pkg.sv
// Shared definitions for the CPU trace path: capture-state encodings and the
// bit layout of one trace word (address / data / control fields).
package nora_pkg;

  typedef enum logic [1:0] {
    TR_IDLE  = 2'd0,
    TR_ARMED = 2'd1,
    TR_POST  = 2'd2,
    TR_DONE  = 2'd3
  } tr_state_t;

  localparam int TRACE_W_DEFAULT = 40;
  localparam int TRACE_ADDR_MSB  = 39;
  localparam int TRACE_ADDR_LSB  = 24;
  localparam int TRACE_DATA_MSB  = 23;
  localparam int TRACE_DATA_LSB  = 16;
  localparam int TRACE_CTRL_MSB  = 11;
  localparam int TRACE_CTRL_LSB  = 0;

  function automatic logic [15:0] trace_addr(input logic [TRACE_W_DEFAULT-1:0] t);
    return t[TRACE_ADDR_MSB:TRACE_ADDR_LSB];
  endfunction

  function automatic logic [7:0] trace_data(input logic [TRACE_W_DEFAULT-1:0] t);
    return t[TRACE_DATA_MSB:TRACE_DATA_LSB];
  endfunction

  function automatic logic [11:0] trace_ctrl(input logic [TRACE_W_DEFAULT-1:0] t);
    return t[TRACE_CTRL_MSB:TRACE_CTRL_LSB];
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Sample/readout bundle between the bus phaser + ICD controller (master) and the
// trace buffer (slave).
interface cpu_trace_buffer_if #(
  parameter int TRACE_W = nora_pkg::TRACE_W_DEFAULT
);
  logic [TRACE_W-1:0] trace_i;
  logic               trace_catch_i;
  logic               rd_pop_i;
  logic [TRACE_W-1:0] rd_data_o;
  logic               rd_valid_o;

  modport master (
    output trace_i, trace_catch_i, rd_pop_i,
    input  rd_data_o, rd_valid_o
  );

  modport slave (
    input  trace_i, trace_catch_i, rd_pop_i,
    output rd_data_o, rd_valid_o
  );
endinterface

// File: rtl/trace_ram.sv
// Simple dual-port RAM with a registered read port, shaped to map onto iCE40 EBR.
module trace_ram #(
  parameter int W  = 40,
  parameter int AW = 9
) (
  input  logic          clk6x,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk6x) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/cpu_trace_buffer.sv
// Triggerable circular trace recorder: stores a bus snapshot on every catch strobe,
// stops a programmable distance past a trigger and replays the history oldest-first.
module cpu_trace_buffer
  import nora_pkg::*;
#(
  parameter int TRACE_W    = TRACE_W_DEFAULT,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk6x,
  input  logic                  resetn,
  cpu_trace_buffer_if.slave     bus,
  input  logic                  arm_i,
  input  logic                  disarm_i,
  input  logic [TRACE_W-1:0]    trig_mask_i,
  input  logic [TRACE_W-1:0]    trig_value_i,
  input  logic                  trig_ext_i,
  input  logic [DEPTH_LOG2-1:0] post_count_i,
  output logic [1:0]            state_o,
  output logic                  triggered_o,
  output logic                  wrapped_o,
  output logic [DEPTH_LOG2:0]   count_o
);
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  tr_state_t             state_reg, state_next;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2-1:0] post_lat_reg, post_lat_next, post_left_reg, post_left_next;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  triggered_reg, triggered_next, wrapped_reg, wrapped_next;
  logic                  fetch_reg, fetch_next, rd_valid_reg, rd_valid_next;
  logic [TRACE_W-1:0]    rd_data_reg, rd_data_next, ram_rdata, miss;
  logic                  ram_we, hit;

  for (genvar gi = 0; gi < TRACE_W; gi++) begin : g_cmp
    assign miss[gi] = (bus.trace_i[gi] ^ trig_value_i[gi]) & trig_mask_i[gi];
  end
  assign hit = bus.trace_catch_i & ((miss == '0) | trig_ext_i);

  trace_ram #(.W(TRACE_W), .AW(DEPTH_LOG2)) u_ram (
    .clk6x (clk6x),
    .we    (ram_we),
    .waddr (wr_ptr_reg),
    .wdata (bus.trace_i),
    .raddr (rd_ptr_reg),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= TR_IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      post_lat_reg  <= '0;
      post_left_reg <= '0;
      triggered_reg <= 1'b0;
      wrapped_reg   <= 1'b0;
      fetch_reg     <= 1'b0;
      rd_valid_reg  <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      post_lat_reg  <= post_lat_next;
      post_left_reg <= post_left_next;
      triggered_reg <= triggered_next;
      wrapped_reg   <= wrapped_next;
      fetch_reg     <= fetch_next;
      rd_valid_reg  <= rd_valid_next;
      rd_data_reg   <= rd_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    post_lat_next  = post_lat_reg;
    post_left_next = post_left_reg;
    triggered_next = triggered_reg;
    wrapped_next   = wrapped_reg;
    fetch_next     = fetch_reg;
    rd_valid_next  = rd_valid_reg;
    rd_data_next   = rd_data_reg;
    ram_we         = 1'b0;

    if (arm_i) begin
      // A DEPTH_LOG2-bit post count can never exceed depth-1, so the trigger
      // sample always survives the post-trigger phase.
      state_next     = TR_ARMED;
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      count_next     = '0;
      post_lat_next  = post_count_i;
      post_left_next = '0;
      triggered_next = 1'b0;
      wrapped_next   = 1'b0;
      fetch_next     = 1'b0;
      rd_valid_next  = 1'b0;
    end else begin
      case (state_reg)
        TR_ARMED, TR_POST: begin
          if (bus.trace_catch_i) begin
            ram_we      = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            if (count_reg == FULL) wrapped_next = 1'b1;
            else                   count_next   = count_reg + 1'b1;
            if (state_reg == TR_ARMED && hit) begin
              triggered_next = 1'b1;
              post_left_next = post_lat_reg;
              state_next     = (post_lat_reg == '0) ? TR_DONE : TR_POST;
            end else if (state_reg == TR_POST) begin
              post_left_next = post_left_reg - 1'b1;
              if (post_left_reg == DEPTH_LOG2'(1)) state_next = TR_DONE;
            end
          end
          if (disarm_i) begin
            state_next     = TR_DONE;
            triggered_next = triggered_reg;
          end
          // Once wrapped, the next slot to be overwritten holds the oldest sample.
          if (state_next == TR_DONE) rd_ptr_next = wrapped_next ? wr_ptr_next : '0;
        end
        TR_DONE: begin
          if (fetch_reg) begin
            rd_data_next  = ram_rdata;
            rd_valid_next = 1'b1;
            fetch_next    = 1'b0;
          end else if (rd_valid_reg) begin
            if (bus.rd_pop_i) begin
              rd_valid_next = 1'b0;
              count_next    = count_reg - 1'b1;
              rd_ptr_next   = rd_ptr_reg + 1'b1;
            end
          end else if (count_reg != '0) begin
            fetch_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o        = state_reg;
  assign triggered_o    = triggered_reg;
  assign wrapped_o      = wrapped_reg;
  assign count_o        = count_reg;
  assign bus.rd_data_o  = rd_data_reg;
  assign bus.rd_valid_o = rd_valid_reg;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: a queue-based model of the capture history
// is compared against the DUT every cycle, plus literal expectations per scenario.
module tb_cpu_trace_buffer;
  import nora_pkg::*;

  localparam int TW    = 40;
  localparam int DL    = 9;
  localparam int DEPTH = 512;

  logic clk6x = 1'b0;
  logic resetn;
  logic arm, disarm, trig_ext;
  logic [TW-1:0] mask, value;
  logic [DL-1:0] post_count;
  logic [1:0]    state;
  logic          triggered, wrapped;
  logic [DL:0]   count;

  always #5 clk6x = ~clk6x;

  cpu_trace_buffer_if #(.TRACE_W(TW)) bus ();

  cpu_trace_buffer #(.TRACE_W(TW), .DEPTH_LOG2(DL)) dut (
    .clk6x        (clk6x),
    .resetn       (resetn),
    .bus          (bus),
    .arm_i        (arm),
    .disarm_i     (disarm),
    .trig_mask_i  (mask),
    .trig_value_i (value),
    .trig_ext_i   (trig_ext),
    .post_count_i (post_count),
    .state_o      (state),
    .triggered_o  (triggered),
    .wrapped_o    (wrapped),
    .count_o      (count)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit hit_rule(input logic [TW-1:0] t, input logic [TW-1:0] m,
                                  input logic [TW-1:0] v, input bit ext);
    return (((t ^ v) & m) == '0) || ext;
  endfunction

  // Model: the capture is a bounded queue of samples, oldest at the front.
  logic [TW-1:0] mq[$];
  int m_state, m_post_lat, m_post_left, m_wait;
  bit m_trig, m_wrap, m_valid;

  always @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_state = 0; m_trig = 0; m_wrap = 0; m_valid = 0; m_wait = 0;
      m_post_lat = 0; m_post_left = 0;
    end else if (arm) begin
      mq.delete();
      m_state = 1; m_trig = 0; m_wrap = 0; m_valid = 0; m_wait = 0;
      m_post_lat = int'(post_count);
    end else if (m_state == 1 || m_state == 2) begin
      if (bus.trace_catch_i) begin
        if (mq.size() == DEPTH) begin
          mq.delete(0);
          m_wrap = 1;
        end
        mq.push_back(bus.trace_i);
      end
      if (disarm) m_state = 3;
      else if (bus.trace_catch_i && m_state == 1 &&
               hit_rule(bus.trace_i, mask, value, trig_ext)) begin
        m_trig = 1;
        m_post_left = m_post_lat;
        m_state = (m_post_lat == 0) ? 3 : 2;
      end else if (bus.trace_catch_i && m_state == 2) begin
        m_post_left--;
        if (m_post_left == 0) m_state = 3;
      end
      if (m_state == 3) m_wait = 2;
    end else if (m_state == 3) begin
      if (m_valid && bus.rd_pop_i) begin
        mq.delete(0);
        m_valid = 0;
        m_wait = 2;
      end else if (!m_valid && m_wait > 0) begin
        m_wait--;
        if (m_wait == 0 && mq.size() > 0) m_valid = 1;
      end
    end
  end

  always @(negedge clk6x) begin
    if (resetn && cmp_en) begin
      chk("model_state", state, m_state);
      chk("model_count", count, mq.size());
      chk("model_triggered", triggered, m_trig);
      chk("model_wrapped", wrapped, m_wrap);
      chk("model_rd_valid", bus.rd_valid_o, m_valid);
      if (m_valid && bus.rd_valid_o) chk("model_rd_data", bus.rd_data_o, mq[0]);
    end
  end

  task automatic cyc();
    @(negedge clk6x);
  endtask

  task automatic catch_s(input logic [TW-1:0] d, input bit ext = 1'b0);
    bus.trace_i = d; bus.trace_catch_i = 1'b1; trig_ext = ext;
    cyc();
    bus.trace_catch_i = 1'b0; trig_ext = 1'b0;
  endtask

  task automatic arm_cap(input int pc);
    post_count = DL'(pc); arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    disarm = 1'b1;
    cyc();
    disarm = 1'b0;
  endtask

  logic [TW-1:0] got[$];

  task automatic drain();
    int idle = 0;
    int guard = 0;
    got.delete();
    while (idle < 6 && guard < 3000) begin
      guard++;
      if (bus.rd_valid_o) begin
        got.push_back(bus.rd_data_o);
        bus.rd_pop_i = 1'b1;
        cyc();
        bus.rd_pop_i = 1'b0;
        idle = 0;
      end else begin
        cyc();
        idle++;
      end
    end
    chk("drain_bound", 64'(guard < 3000), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] exp_d;
    arm = 0; disarm = 0; trig_ext = 0; mask = '0; value = '0; post_count = '0;
    bus.trace_i = '0; bus.trace_catch_i = 1'b0; bus.rd_pop_i = 1'b0;
    resetn = 1'b0;
    repeat (3) cyc();
    chk("rst_state", state, 0);
    chk("rst_count", count, 0);
    chk("rst_trig", triggered, 0);
    chk("rst_wrap", wrapped, 0);
    chk("rst_valid", bus.rd_valid_o, 0);
    chk("rst_data", bus.rd_data_o, 0);
    resetn = 1'b1;
    cmp_en = 1'b1;

    catch_s(40'h5);
    chk("idle_catch_count", count, 0);

    // Fill without trigger: 600 catches into 512 slots
    mask = '1; value = '1;
    arm_cap(0);
    chk("arm_state", state, 1);
    for (int i = 0; i < 600; i++) catch_s(TW'(i));
    chk("fill_count", count, 512);
    chk("fill_wrapped", wrapped, 1);
    chk("fill_trig", triggered, 0);
    pulse_disarm();
    chk("fill_done", state, 3);
    drain();
    chk("fill_n", got.size(), 512);
    for (int k = 0; k < got.size(); k++) chk("fill_data", got[k], 64'(88 + k));
    chk("fill_end_valid", bus.rd_valid_o, 0);
    chk("fill_end_count", count, 0);

    // Masked trigger on address field 0xFFFC, post count 3
    mask = 40'hFF_FF00_0000; value = 40'hFF_FC00_0000;
    arm_cap(3);
    for (int i = 0; i < 10; i++) catch_s({16'(16'h1000 + i), 24'(i * 3)});
    catch_s({16'hFFFC, 24'h123456});
    chk("mask_trig", triggered, 1);
    chk("mask_post", state, 2);
    for (int j = 0; j < 5; j++) begin
      catch_s({16'(16'h2000 + j), 24'h0});
      if (j == 1) chk("mask_post_still", state, 2);
      if (j == 2) chk("mask_done", state, 3);
    end
    chk("mask_count", count, 14);
    chk("mask_wrapped", wrapped, 0);
    drain();
    chk("mask_n", got.size(), 14);
    for (int k = 0; k < got.size(); k++) begin
      if (k < 10)       exp_d = {16'(16'h1000 + k), 24'(k * 3)};
      else if (k == 10) exp_d = {16'hFFFC, 24'h123456};
      else              exp_d = {16'(16'h2000 + k - 11), 24'h0};
      chk("mask_data", got[k], exp_d);
    end
    if (got.size() > 10) chk("mask_trig_addr", trace_addr(got[10]), 16'hFFFC);

    // External trigger with post count 0
    mask = '1; value = '0;
    arm_cap(0);
    for (int i = 1; i <= 6; i++) begin
      catch_s(TW'(40'h100 + i), i == 5);
      if (i == 5) begin
        chk("ext_done", state, 3);
        chk("ext_count5", count, 5);
        chk("ext_trig", triggered, 1);
      end
    end
    chk("ext_count6", count, 5);
    drain();
    chk("ext_n", got.size(), 5);
    for (int k = 0; k < got.size(); k++) chk("ext_data", got[k], 64'(40'h101 + k));

    // Read latency with two samples
    mask = '1; value = '1;
    arm_cap(0);
    catch_s(40'hAA_0000_0001);
    catch_s(40'hBB_0000_0002);
    pulse_disarm();
    chk("lat_done", state, 3);
    chk("lat_v0", bus.rd_valid_o, 0);
    cyc();
    chk("lat_v1", bus.rd_valid_o, 0);
    cyc();
    chk("lat_v2", bus.rd_valid_o, 1);
    chk("lat_dA", bus.rd_data_o, 40'hAA_0000_0001);
    chk("lat_cnt2", count, 2);
    bus.rd_pop_i = 1'b1;
    cyc();
    chk("lat_pop_v", bus.rd_valid_o, 0);
    chk("lat_cnt1", count, 1);
    cyc();
    chk("lat_badpop_cnt", count, 1);
    chk("lat_badpop_v", bus.rd_valid_o, 0);
    bus.rd_pop_i = 1'b0;
    cyc();
    chk("lat_vB", bus.rd_valid_o, 1);
    chk("lat_dB", bus.rd_data_o, 40'hBB_0000_0002);
    bus.rd_pop_i = 1'b1;
    cyc();
    bus.rd_pop_i = 1'b0;
    chk("lat_cnt0", count, 0);
    repeat (4) cyc();
    chk("lat_empty_v", bus.rd_valid_o, 0);
    chk("lat_empty_state", state, 3);

    // arm + disarm + catch together, then pop while ARMED
    arm = 1'b1; disarm = 1'b1; bus.trace_catch_i = 1'b1; bus.trace_i = 40'h77;
    cyc();
    arm = 1'b0; disarm = 1'b0; bus.trace_catch_i = 1'b0;
    chk("simul_state", state, 1);
    chk("simul_count", count, 0);
    catch_s(40'h1);
    catch_s(40'h2);
    bus.rd_pop_i = 1'b1;
    cyc();
    bus.rd_pop_i = 1'b0;
    chk("armed_pop_count", count, 2);
    chk("armed_pop_state", state, 1);

    // Async reset in the middle of POST
    mask = '0;
    arm_cap(5);
    catch_s(40'h10);
    catch_s(40'h11);
    chk("post_state", state, 2);
    chk("post_trig", triggered, 1);
    #2 resetn = 1'b0;
    #1;
    chk("areset_state", state, 0);
    chk("areset_count", count, 0);
    chk("areset_trig", triggered, 0);
    chk("areset_valid", bus.rd_valid_o, 0);
    chk("areset_data", bus.rd_data_o, 0);
    cyc();
    resetn = 1'b1;
    pulse_disarm();
    chk("idle_disarm", state, 0);
    mask = '1; value = '1;
    arm_cap(0);
    chk("rearm_state", state, 1);
    chk("rearm_count", count, 0);
    for (int i = 0; i < 3; i++) catch_s(TW'(40'h300 + i));
    chk("rearm_count3", count, 3);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
